// File: rtl/cla_pipe_adder_pkg.sv
// cla_pipe_adder_pkg: shared ALU constants and the result flag bundle.
package cla_pipe_adder_pkg;
    localparam int NIBBLE_W = 4;

    typedef struct packed {
        logic c;
        logic v;
        logic z;
        logic n;
    } alu_flags_t;
endpackage

// File: rtl/cla_pipe_adder_cla.sv
// carry_lookahead_unit: 4-bit lookahead producing per-bit carry-ins and the nibble carry-out.
module carry_lookahead_unit
    import cla_pipe_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] g,
    input  logic [NIBBLE_W-1:0] p,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] c,
    output logic                cout
);
    always_comb begin
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
    end
endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: nibble-serial pipelined adder/subtractor, one lookahead nibble per stage.
module cla_pipe_adder
    import cla_pipe_adder_pkg::*;
#(
    parameter int NIBBLES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]  in_a,
    input  logic [NIBBLE_W*NIBBLES-1:0]  in_b,
    input  logic                         in_sub,
    input  logic                         in_cin,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]  out_sum,
    output logic                         out_c,
    output logic                         out_v,
    output logic                         out_z,
    output logic                         out_n
);
    localparam int W = NIBBLE_W * NIBBLES;

    // Index s holds what stage s consumes; operands are pre-shifted so nibble s sits at [3:0].
    logic [W-1:0] a_s [NIBBLES];
    logic [W-1:0] b_s [NIBBLES];
    logic [W-1:0] sum_s [NIBBLES];
    logic         v_s [NIBBLES];
    logic         cy_s [NIBBLES];

    logic         adv, v_o, cy_o, c3_o;
    logic [W-1:0] sum_o;
    alu_flags_t   flags;

    assign adv      = ~v_o | out_ready;
    assign in_ready = adv;
    assign a_s[0]   = in_a;
    assign b_s[0]   = in_b ^ {W{in_sub}};
    assign sum_s[0] = '0;
    assign v_s[0]   = in_valid;
    assign cy_s[0]  = in_cin ^ in_sub;

    for (genvar s = 0; s < NIBBLES; s++) begin : g_st
        logic [NIBBLE_W-1:0] g, p, c;
        logic                cout;
        logic                v_d, v_q, cy_d, cy_q;
        logic [W-1:0]        sum_d, sum_q;

        assign g = a_s[s][NIBBLE_W-1:0] & b_s[s][NIBBLE_W-1:0];
        assign p = a_s[s][NIBBLE_W-1:0] ^ b_s[s][NIBBLE_W-1:0];

        carry_lookahead_unit u_cla (
            .g    (g),
            .p    (p),
            .cin  (cy_s[s]),
            .c    (c),
            .cout (cout)
        );

        always_comb begin
            v_d   = v_s[s];
            cy_d  = cout;
            sum_d = sum_s[s] | (W'(p ^ c) << (NIBBLE_W * s));
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q   <= 1'b0;
                cy_q  <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                v_q   <= v_d;
                cy_q  <= cy_d;
                sum_q <= sum_d;
            end
        end

        if (s < NIBBLES - 1) begin : g_fwd
            logic [W-1:0] a_d, a_q, b_d, b_q;

            always_comb begin
                a_d = a_s[s] >> NIBBLE_W;
                b_d = b_s[s] >> NIBBLE_W;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end

            assign a_s[s+1]   = a_q;
            assign b_s[s+1]   = b_q;
            assign sum_s[s+1] = sum_q;
            assign v_s[s+1]   = v_q;
            assign cy_s[s+1]  = cy_q;
        end else begin : g_out
            // Carry into the top bit is kept only here, where overflow is resolved.
            logic c3_d, c3_q;

            always_comb c3_d = c[NIBBLE_W-1];

            always_ff @(posedge clk) begin
                if (rst) c3_q <= 1'b0;
                else if (adv) c3_q <= c3_d;
            end

            assign v_o   = v_q;
            assign cy_o  = cy_q;
            assign c3_o  = c3_q;
            assign sum_o = sum_q;
        end
    end

    assign flags = '{c: cy_o, v: cy_o ^ c3_o, z: (sum_o == '0), n: sum_o[W-1]};

    assign out_valid = v_o;
    assign out_sum   = sum_o;
    assign out_c     = flags.c;
    assign out_v     = flags.v;
    assign out_z     = flags.z;
    assign out_n     = flags.n;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed vectors on an 8-bit build plus random streams on 4/8/16-bit builds.
module tb_cla_pipe_adder;
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic       cin;
        logic [7:0] sum;
        logic       c;
        logic       v;
        logic       z;
        logic       n;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
        int          stamp;
    } exp_t;

    logic clk = 1'b0;
    int   nvec = 0;
    int   nerr = 0;
    bit   rdone [3];

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h, required %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic exp_t ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                       input logic sub, input logic cin);
        exp_t   e;
        longint m, h, r, rm, sa, sb, sr;
        m  = longint'(1) << w;
        h  = m / 2;
        r  = sub ? longint'(a) - longint'(b) - longint'(cin) : longint'(a) + longint'(b) + longint'(cin);
        rm = ((r % m) + m) % m;
        sa = (longint'(a) >= h) ? longint'(a) - m : longint'(a);
        sb = (longint'(b) >= h) ? longint'(b) - m : longint'(b);
        sr = sub ? sa - sb - longint'(cin) : sa + sb + longint'(cin);
        e.sum   = 32'(rm);
        e.c     = sub ? (r >= 0) : (r >= m);
        e.v     = (sr < -h) || (sr >= h);
        e.z     = (rm == 0);
        e.n     = (rm >= h);
        e.stamp = 0;
        return e;
    endfunction

    logic       d_rst = 1'b1, d_iv = 1'b0, d_ir, d_sub = 1'b0, d_cin = 1'b0;
    logic       d_ov, d_or = 1'b1, d_c, d_v, d_z, d_n;
    logic [7:0] d_a = '0, d_b = '0, d_s;

    cla_pipe_adder #(.NIBBLES(2)) u_dut (
        .clk       (clk),
        .rst       (d_rst),
        .in_valid  (d_iv),
        .in_ready  (d_ir),
        .in_a      (d_a),
        .in_b      (d_b),
        .in_sub    (d_sub),
        .in_cin    (d_cin),
        .out_valid (d_ov),
        .out_ready (d_or),
        .out_sum   (d_s),
        .out_c     (d_c),
        .out_v     (d_v),
        .out_z     (d_z),
        .out_n     (d_n)
    );

    for (genvar k = 0; k < 3; k++) begin : g_rnd
        localparam int NN = (k == 0) ? 1 : ((k == 1) ? 2 : 4);
        localparam int RW = 4 * NN;
        logic          r_rst = 1'b1, iv = 1'b0, ir, sub = 1'b0, cin = 1'b0;
        logic          ov, orr = 1'b0, o_c, o_v, o_z, o_n;
        logic [RW-1:0] a = '0, b = '0, s;

        cla_pipe_adder #(.NIBBLES(NN)) u_dut (
            .clk       (clk),
            .rst       (r_rst),
            .in_valid  (iv),
            .in_ready  (ir),
            .in_a      (a),
            .in_b      (b),
            .in_sub    (sub),
            .in_cin    (cin),
            .out_valid (ov),
            .out_ready (orr),
            .out_sum   (s),
            .out_c     (o_c),
            .out_v     (o_v),
            .out_z     (o_z),
            .out_n     (o_n)
        );

        // A transaction is due at the output once NN-1 advancing edges have followed its accept.
        initial begin
            exp_t q[$];
            exp_t e;
            int   ac  = 0;
            int   acc = 0;
            logic ev;
            repeat (2) @(negedge clk);
            r_rst = 1'b0;
            for (int cyc = 0; cyc < 20000 && acc < 1000; cyc++) begin
                @(negedge clk);
                ev = (q.size() > 0) && (ac - q[0].stamp == NN - 1);
                chk($sformatf("rnd%0d_valid", NN), 64'(ov), 64'(ev));
                if (ev)
                    chk($sformatf("rnd%0d_result", NN), 64'({s, o_c, o_v, o_z, o_n}),
                        64'({q[0].sum[RW-1:0], q[0].c, q[0].v, q[0].z, q[0].n}));
                orr = ($urandom_range(0, 3) != 0);
                iv  = ($urandom_range(0, 3) != 0);
                a   = RW'($urandom);
                b   = RW'($urandom);
                sub = 1'($urandom);
                cin = 1'($urandom);
                #1;
                chk($sformatf("rnd%0d_in_ready", NN), 64'(ir), 64'(!ev || orr));
                if (!ev || orr) begin
                    ac++;
                    if (ev) void'(q.pop_front());
                    if (iv) begin
                        e       = ref_model(RW, 32'(a), 32'(b), sub, cin);
                        e.stamp = ac;
                        q.push_back(e);
                        acc++;
                    end
                end
            end
            chk($sformatf("rnd%0d_accepted", NN), 64'(acc >= 1000), 64'(1));
            rdone[k] = 1'b1;
        end
    end

    initial begin
        vec_t       vt [9];
        vec_t       bp [5];
        logic [7:0] held;
        logic       was_stall, saw_block;
        int         sent, got;

        vt[0] = '{8'h7f, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[1] = '{8'hff, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[2] = '{8'h0f, 8'h00, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[3] = '{8'h05, 8'h07, 1'b1, 1'b0, 8'hfe, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[4] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7f, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[5] = '{8'h05, 8'h05, 1'b1, 1'b1, 8'hff, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[6] = '{8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[7] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[8] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(d_ov), 64'(0));
        chk("rst_sum", 64'(d_s), 64'(0));
        chk("rst_flags_cvzn", 64'({d_c, d_v, d_z, d_n}), 64'(4'b0010));
        d_rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(d_ir), 64'(1));

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            d_a = vt[i].a; d_b = vt[i].b; d_sub = vt[i].sub; d_cin = vt[i].cin; d_iv = 1'b1;
            @(negedge clk);
            d_iv = 1'b0;
            chk($sformatf("vec%0d_early", i), 64'(d_ov), 64'(0));
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 64'(d_ov), 64'(1));
            chk($sformatf("vec%0d_sum", i), 64'(d_s), 64'(vt[i].sum));
            chk($sformatf("vec%0d_cvzn", i), 64'({d_c, d_v, d_z, d_n}),
                64'({vt[i].c, vt[i].v, vt[i].z, vt[i].n}));
        end

        // Backpressure: consumer stalls for 4 cycles starting on the third cycle.
        for (int i = 0; i < 5; i++) begin
            bp[i].a = 8'(i * 8'h37 + 8'h29);
            bp[i].b = 8'(i * 8'h15 + 8'h0c);
        end
        sent = 0; got = 0; was_stall = 1'b0; saw_block = 1'b0; held = '0;
        d_sub = 1'b0; d_cin = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            @(negedge clk);
            if (was_stall) chk("bp_hold_sum", 64'(d_s), 64'(held));
            d_or = !(cyc >= 2 && cyc < 6);
            #1;
            if (d_ov && !d_or) begin
                chk("bp_in_ready_low", 64'(d_ir), 64'(0));
                saw_block = 1'b1;
            end
            d_iv = (sent < 5);
            if (sent < 5) begin
                d_a = bp[sent].a;
                d_b = bp[sent].b;
                if (d_ir) sent++;
            end
            if (d_ov && d_or) begin
                chk($sformatf("bp_result%0d", got), 64'(d_s), 64'(8'(bp[got].a + bp[got].b)));
                got++;
            end
            was_stall = d_ov && !d_or;
            held      = d_s;
        end
        chk("bp_got5", 64'(got), 64'(5));
        chk("bp_blocked", 64'(saw_block), 64'(1));
        @(negedge clk);
        d_iv = 1'b0;
        repeat (3) @(negedge clk);
        chk("bp_no_extra", 64'(d_ov), 64'(0));

        // Reset with two transactions in flight.
        d_or = 1'b0;
        d_a = 8'h12; d_b = 8'h34; d_iv = 1'b1;
        @(negedge clk);
        d_a = 8'h56; d_b = 8'h78;
        @(negedge clk);
        d_iv = 1'b0;
        chk("rmid_inflight", 64'(d_ov), 64'(1));
        d_rst = 1'b1;
        @(negedge clk);
        chk("rmid_valid", 64'(d_ov), 64'(0));
        chk("rmid_sum", 64'(d_s), 64'(0));
        chk("rmid_z", 64'(d_z), 64'(1));
        chk("rmid_in_ready", 64'(d_ir), 64'(1));
        d_rst = 1'b0;
        d_or  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rmid_no_stale", 64'(d_ov), 64'(0));
        end

        for (int i = 0; i < 30000 && !(rdone[0] && rdone[1] && rdone[2]); i++) @(posedge clk);
        chk("rnd_finished", 64'(rdone[0] && rdone[1] && rdone[2]), 64'(1));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Pipelined ripple-of-lookahead adder/subtractor that feeds 4-bit nibbles through `carry_lookahead_unit` one nibble per stage and registers the inter-nibble carry between stages. It sits directly upstream of the ALU result/flag mux. It accepts one operand pair per cycle through a valid/ready handshake and returns the sum plus C/V/Z/N flags a fixed NIBBLES cycles later. Backpressure stalls the whole pipe.

## Interface
- `NIBBLES`, default 2: number of 4-bit slices. Data width W = 4*NIBBLES. Latency = NIBBLES cycles. Legal range is 1–8.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_valid` input, 1 bit: operand pair present.
- `in_ready` output, 1 bit: pipe can accept this cycle.
- `in_a` input, W bits: operand A.
- `in_b` input, W bits: operand B.
- `in_sub` input, 1 bit: 1 = subtract (A − B).
- `in_cin` input, 1 bit: carry/borrow chain input.
- `out_valid` output, 1 bit: result present.
- `out_ready` input, 1 bit: consumer takes result.
- `out_sum` output, W bits: result.
- `out_c` output, 1 bit: carry out of bit W−1. For subtract, 1 = no borrow.
- `out_v` output, 1 bit: signed overflow.
- `out_z` output, 1 bit: out_sum == 0.
- `out_n` output, 1 bit: out_sum[W−1].

## Operation
- Operand preparation at accept:
  - B' = in_sub ? ~in_b : in_b.
  - c0 = in_cin ^ in_sub. So sub with cin=0 gives A−B, and sub with cin=1 gives A−B−1.
- Stage k (1..NIBBLES) processes nibble k−1:
  - g = a & b', p = a ^ b'.
  - carry_lookahead_unit(G=g, P=p, Cin=carry) produces C[3:0] and Cout.
  - sum nibble = p ^ C.
  - The stage registers: sum nibbles [0..k−1], the not-yet-processed high nibbles of A and B', Cout as the next carry, C[3] of the current nibble (needed for V), and a valid bit.
- The last stage register is the output register:
  - out_c = final Cout.
  - out_v = Cout ^ C[3] of the top nibble.
  - out_z and out_n are computed combinationally from the registered out_sum.
- Global advance: adv = ~out_valid | out_ready. Every stage register (data and valid) loads only when adv = 1, so bubbles are not collapsed.
- in_ready = adv. A transfer happens when in_valid & in_ready. When in_valid = 0 on an advancing cycle, stage 1 loads valid = 0.
- No state machine beyond the per-stage valid bits. Occupancy is at most NIBBLES transactions.

## Timing
- Reset: all stage valid bits and data registers go to 0.
  - out_valid = 0, out_sum = 0, out_c = out_v = out_n = 0.
  - out_z = 1, since it is derived from sum = 0.
  - in_ready = 1 in the first cycle after reset.
- Latency: an operand accepted at edge t appears with out_valid = 1 after edge t+NIBBLES−1, i.e. NIBBLES register stages.
- Throughput: one result per cycle while out_ready = 1.
- Stall: while out_valid & ~out_ready:
  - out_sum and all flags hold stable.
  - in_ready = 0.
  - No stage register changes.
- Simultaneous out_ready and in_valid while full: the output retires, and the new operand enters in the same edge.
- rst asserted mid-operation drops all in-flight transactions in that edge; none are emitted.
- Wrap-around: sums are modulo 2^W. Carry is reported only through out_c.

## Structure
- Shared ALU package:
  - `NIBBLE_W` = 4.
  - A flags struct `alu_flags_t` {c, v, z, n}, used on the output side.
- Sub-module: one `carry_lookahead_unit` instance per stage, generated by a for-loop over NIBBLES. No new sub-module is created.
- Per-stage registers are a generated array indexed by stage. Unconsumed high-nibble fields narrow by 4 bits per stage.

## Test plan
All cases use NIBBLES = 2 unless stated.
- Add 0x7F + 0x01, sub=0, cin=0 → out_sum=0x80, c=0, v=1, n=1, z=0, out_valid exactly 2 cycles after accept.
- Add 0xFF + 0x01 → sum=0x00, c=1, v=0, z=1. Adc 0x0F + 0x00 with cin=1 → 0x10, which exercises the inter-nibble carry register.
- Sub 0x05 − 0x07, cin=0 → 0xFE, c=0, n=1, v=0. Sub 0x80 − 0x01 → 0x7F, v=1, c=1.
- Backpressure:
  - Stimulus: stream 5 operands with out_ready=0 from cycle 2; release after 4 cycles.
  - Required: in_ready drops once 2 transactions are in flight; out_sum is stable while stalled; all 5 results arrive in order with no loss or duplication.
- Reset mid-stream: assert rst with 2 transactions in flight → next cycle out_valid=0, sum=0, z=1, in_ready=1. No stale result ever appears.
- NIBBLES=1 and NIBBLES=4 builds: random 1000 operands with random in_valid/out_ready patterns vs. a reference model (A ± B ± cin, with flags) → all results match, and latency equals NIBBLES.
